// File: rtl/pkt_buf_scheduler.sv
// pkt_buf_scheduler
//   Hands ownership of the shared packet buffer around a fixed ring:
//   network receive fills it, the pipeline processor works on it, network
//   transmit drains it. Exactly one owner is enabled at a time. A watchdog
//   drops the packet if the processor holds the buffer too long. Packet and
//   drop statistics are kept for the hardware registers.
//
//   Ports
//     clk, reset        system clock, synchronous active-high reset
//     sw_enable         software enable; disabling takes effect at a packet boundary
//     sw_inst_load      instruction memory load; aborts sequencing, holds IDLE
//     rx_sop, rx_eop    first / last word of a packet written into the buffer
//     cpu_done          processor finished with the packet
//     tx_eop            last word of a packet sent out
//     rx_en, cpu_run,   per-owner enables (registered)
//     tx_en
//     cpu_pc_clear      one-cycle pulse on PROC entry: force PC to 0
//     buf_reset         one-cycle pulse: reset buffer head/tail pointers
//     timeout           one-cycle pulse: watchdog expired, packet dropped
//     state             0 IDLE, 1 RX, 2 PROC, 3 TX
//     pkt_count         packets fully transmitted (saturating)
//     drop_count        packets dropped by the watchdog (saturating)
module pkt_buf_scheduler #(
   parameter int TIMEOUT   = 1024,
   parameter int TO_WIDTH  = 11,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sw_enable,
   input  logic                 sw_inst_load,
   input  logic                 rx_sop,
   input  logic                 rx_eop,
   input  logic                 cpu_done,
   input  logic                 tx_eop,
   output logic                 rx_en,
   output logic                 cpu_run,
   output logic                 cpu_pc_clear,
   output logic                 tx_en,
   output logic                 buf_reset,
   output logic                 timeout,
   output logic [1:0]           state,
   output logic [CNT_WIDTH-1:0] pkt_count,
   output logic [CNT_WIDTH-1:0] drop_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RX   = 2'd1;
   localparam logic [1:0] S_PROC = 2'd2;
   localparam logic [1:0] S_TX   = 2'd3;

   localparam logic [TO_WIDTH-1:0] WD_LAST = TO_WIDTH'(TIMEOUT - 1);

   logic [TO_WIDTH-1:0] watchdog;
   logic                rx_busy;
   logic                load_d;     // previous sw_inst_load, to pulse buf_reset once
   logic [1:0]          state_nxt;
   logic                rx_busy_nxt;
   logic                drop_evt;
   logic                tx_evt;

   always_comb begin
      state_nxt   = state;
      rx_busy_nxt = rx_busy;
      drop_evt    = 1'b0;
      tx_evt      = 1'b0;
      if (sw_inst_load) begin
         state_nxt   = S_IDLE;
         rx_busy_nxt = 1'b0;
      end else begin
         case (state)
            S_IDLE: if (sw_enable) state_nxt = S_RX;
            S_RX: begin
               // eop checked first so a 1-word packet (sop & eop) goes straight to PROC
               if (rx_eop) begin
                  state_nxt   = S_PROC;
                  rx_busy_nxt = 1'b0;
               end else if (rx_sop) begin
                  rx_busy_nxt = 1'b1;
               end else if (!sw_enable && !rx_busy) begin
                  state_nxt = S_IDLE;
               end
            end
            S_PROC: begin
               // done in the expiry cycle wins: the packet is not dropped
               if (cpu_done) begin
                  state_nxt = S_TX;
               end else if (watchdog == WD_LAST) begin
                  drop_evt  = 1'b1;
                  state_nxt = sw_enable ? S_RX : S_IDLE;
               end
            end
            S_TX: begin
               if (tx_eop) begin
                  tx_evt    = 1'b1;
                  state_nxt = sw_enable ? S_RX : S_IDLE;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         rx_busy      <= 1'b0;
         load_d       <= 1'b0;
         watchdog     <= '0;
         rx_en        <= 1'b0;
         cpu_run      <= 1'b0;
         cpu_pc_clear <= 1'b0;
         tx_en        <= 1'b0;
         buf_reset    <= 1'b0;
         timeout      <= 1'b0;
         pkt_count    <= '0;
         drop_count   <= '0;
      end else begin
         state        <= state_nxt;
         rx_busy      <= rx_busy_nxt;
         load_d       <= sw_inst_load;
         // outputs are decoded from the next state so they line up with it
         rx_en        <= (state_nxt == S_RX);
         cpu_run      <= (state_nxt == S_PROC);
         tx_en        <= (state_nxt == S_TX);
         cpu_pc_clear <= (state_nxt == S_PROC) && (state != S_PROC);
         timeout      <= drop_evt;
         buf_reset    <= drop_evt | (sw_inst_load & ~load_d);
         // counts only while staying in PROC, so it restarts at 0 on every entry
         if (state == S_PROC && state_nxt == S_PROC)
            watchdog <= watchdog + TO_WIDTH'(1);
         else
            watchdog <= '0;
         if (drop_evt && drop_count != {CNT_WIDTH{1'b1}})
            drop_count <= drop_count + CNT_WIDTH'(1);
         if (tx_evt && pkt_count != {CNT_WIDTH{1'b1}})
            pkt_count <= pkt_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_pkt_buf_scheduler.sv
module tb_pkt_buf_scheduler;

   logic       clk = 1'b0;
   logic       reset, sw_enable, sw_inst_load;
   logic       rx_sop, rx_eop, cpu_done, tx_eop;
   logic       rx_en, cpu_run, cpu_pc_clear, tx_en, buf_reset, timeout;
   logic [1:0] state;
   logic [3:0] pkt_count, drop_count;

   int tests = 0;
   int fails = 0;

   pkt_buf_scheduler #(.TIMEOUT(16), .TO_WIDTH(5), .CNT_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .sw_enable(sw_enable), .sw_inst_load(sw_inst_load),
      .rx_sop(rx_sop), .rx_eop(rx_eop), .cpu_done(cpu_done), .tx_eop(tx_eop),
      .rx_en(rx_en), .cpu_run(cpu_run), .cpu_pc_clear(cpu_pc_clear), .tx_en(tx_en),
      .buf_reset(buf_reset), .timeout(timeout), .state(state),
      .pkt_count(pkt_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pkt1();
      rx_sop = 1; rx_eop = 1; tick(); rx_sop = 0; rx_eop = 0;
   endtask

   task automatic done_pulse();
      cpu_done = 1; tick(); cpu_done = 0;
   endtask

   task automatic txeop_pulse();
      tx_eop = 1; tick(); tx_eop = 0;
   endtask

   initial begin
      reset = 1; sw_enable = 0; sw_inst_load = 0;
      rx_sop = 0; rx_eop = 0; cpu_done = 0; tx_eop = 0;
      tick(); tick();
      chk("rst_state", state, 0);
      chk("rst_rx_en", rx_en, 0);
      chk("rst_cpu_run", cpu_run, 0);
      chk("rst_tx_en", tx_en, 0);
      chk("rst_buf_reset", buf_reset, 0);
      chk("rst_pkt", pkt_count, 0);
      chk("rst_drop", drop_count, 0);

      // 1: enable, 5-word packet
      reset = 0; sw_enable = 1;
      tick();
      chk("t1_state_rx", state, 1);
      chk("t1_rx_en", rx_en, 1);
      rx_sop = 1; tick(); rx_sop = 0;
      tick(); tick(); tick();
      chk("t1_still_rx", state, 1);
      rx_eop = 1; tick(); rx_eop = 0;
      chk("t1_state_proc", state, 2);
      chk("t1_pc_clear", cpu_pc_clear, 1);
      chk("t1_cpu_run", cpu_run, 1);
      chk("t1_rx_en_off", rx_en, 0);
      tick();
      chk("t1_pc_clear_pulse", cpu_pc_clear, 0);
      chk("t1_cpu_run_hold", cpu_run, 1);

      // 2: done after a few cycles, then transmit
      tick(); tick();
      done_pulse();
      chk("t2_state_tx", state, 3);
      chk("t2_tx_en", tx_en, 1);
      chk("t2_cpu_run_off", cpu_run, 0);
      tick();
      chk("t2_tx_hold", state, 3);
      txeop_pulse();
      chk("t2_pkt", pkt_count, 1);
      chk("t2_state_rx", state, 1);
      chk("t2_tx_en_off", tx_en, 0);
      done_pulse();
      chk("t2_done_ignored_rx", state, 1);

      // 3: watchdog expiry at PROC cycle 16
      pkt1();
      chk("t3_proc", state, 2);
      txeop_pulse();                       // ignored in PROC; now in cycle 2
      chk("t3_txeop_ignored", state, 2);
      chk("t3_pkt_hold", pkt_count, 1);
      for (int i = 0; i < 14; i++) tick(); // now in cycle 16
      chk("t3_pre_expiry", state, 2);
      chk("t3_pre_timeout", timeout, 0);
      tick();
      chk("t3_timeout", timeout, 1);
      chk("t3_buf_reset", buf_reset, 1);
      chk("t3_drop", drop_count, 1);
      chk("t3_state_rx", state, 1);
      chk("t3_cpu_run_off", cpu_run, 0);
      tick();
      chk("t3_timeout_pulse", timeout, 0);
      chk("t3_buf_reset_pulse", buf_reset, 0);

      // 3b: done in the expiry cycle wins
      pkt1();
      for (int i = 0; i < 15; i++) tick();
      done_pulse();
      chk("t3b_state_tx", state, 3);
      chk("t3b_drop_hold", drop_count, 1);
      chk("t3b_no_timeout", timeout, 0);
      txeop_pulse();
      chk("t3b_pkt", pkt_count, 2);

      // 4: disable mid-packet waits for the boundary
      rx_sop = 1; tick(); rx_sop = 0;
      sw_enable = 0;
      tick();
      chk("t4_hold_rx", state, 1);
      rx_eop = 1; tick(); rx_eop = 0;
      chk("t4_proc", state, 2);
      done_pulse();
      chk("t4_tx", state, 3);
      txeop_pulse();
      chk("t4_idle", state, 0);
      chk("t4_pkt", pkt_count, 3);
      chk("t4_rx_en_off", rx_en, 0);
      tick();
      chk("t4_idle_hold", state, 0);
      sw_enable = 1; tick();
      chk("t4_rx_again", state, 1);
      sw_enable = 0; tick();
      chk("t4_idle_no_pkt", state, 0);
      sw_enable = 1; tick();
      chk("t4_rx_third", state, 1);

      // 5: instruction load during PROC
      pkt1();
      tick();
      chk("t5_proc", state, 2);
      sw_inst_load = 1; tick();
      chk("t5_idle", state, 0);
      chk("t5_cpu_run_off", cpu_run, 0);
      chk("t5_buf_reset", buf_reset, 1);
      chk("t5_pkt_hold", pkt_count, 3);
      chk("t5_drop_hold", drop_count, 1);
      tick();
      chk("t5_idle_held", state, 0);
      chk("t5_buf_reset_pulse", buf_reset, 0);
      sw_inst_load = 0; tick();
      chk("t5_resume_rx", state, 1);

      // 6: saturate pkt_count (4 bits) with 1-word packets
      for (int i = 0; i < 12; i++) begin
         pkt1(); done_pulse(); txeop_pulse();
      end
      chk("t6_pkt_max", pkt_count, 15);
      pkt1();
      chk("t6_one_word_proc", state, 2);
      done_pulse(); txeop_pulse();
      chk("t6_pkt_saturated", pkt_count, 15);
      chk("t6_state_rx", state, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
